// File: rtl/exreg_pkg.sv
// Shared types and helpers for the decode->execute pipeline register:
// control FSM encoding, default widths and the payload bundle width.
package exreg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_t;

  localparam int DW_DEF  = 16;
  localparam int AW_DEF  = 4;
  localparam int PCW_DEF = 12;
  localparam int FW_DEF  = 2;

  // RegWrite, MemWrite and MemRead travel in the top bits of the payload.
  localparam int CTL_W = 3;

  function automatic int payloadWidth(input int fw, input int dw, input int aw, input int pcw);
    return CTL_W + fw + 2 * dw + aw + pcw;
  endfunction

endpackage

// File: rtl/exreg_payload_reg.sv
// Enabled payload register with asynchronous active-low reset; one instance
// holds the instruction shown to execute, the other is the skid entry.
module exreg_payload_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: payload is cleared on reset (not just the valid bit) so the E outputs
  // read as all-zero while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/exec_stage_pipe.sv
// Decode->execute pipeline register with valid/ready handshake, 2-entry skid,
// flush and bubble insertion. Define EXREG_PERF_CNT_EN for stall/flush counters.
module exec_stage_pipe
  import exreg_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int PCW  = PCW_DEF,
  parameter int FW   = FW_DEF,
  parameter int CNTW = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           validD,
  output logic           readyD,
  input  logic           RegWriteD,
  input  logic           MemWriteD,
  input  logic           MemReadD,
  input  logic [FW-1:0]  aluFuncD,
  input  logic [DW-1:0]  srcDataD1,
  input  logic [DW-1:0]  srcDataD2,
  input  logic [AW-1:0]  destAddD,
  input  logic [PCW-1:0] pcD,
  input  logic           flushE,
  output logic           validE,
  input  logic           readyE,
  output logic           RegWriteE,
  output logic           MemWriteE,
  output logic           MemReadE,
  output logic [FW-1:0]  aluFuncE,
  output logic [DW-1:0]  srcDataE1,
  output logic [DW-1:0]  srcDataE2,
  output logic [AW-1:0]  destAddE,
  output logic [PCW-1:0] pcE
`ifdef EXREG_PERF_CNT_EN
  , output logic [CNTW-1:0] stallCntE
  , output logic [CNTW-1:0] flushCntE
`endif
);

  localparam int PW = payloadWidth(FW, DW, AW, PCW);

  state_t        state, stateNext;
  logic          readyQ;
  logic          validInt, accD;
  logic          loadMainD, loadMainSkid, loadSkid, clearCtl, mainEn;
  logic [PW-1:0] dPayload, mainD, mainQ, skidQ;

  assign validInt = (state == BUSY) || (state == FULL);
  assign validE   = validInt;
  assign readyD   = readyQ;
  assign accD     = validD & readyQ;
  assign dPayload = {RegWriteD, MemWriteD, MemReadD, aluFuncD, srcDataD1, srcDataD2, destAddD, pcD};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    stateNext    = state;
    loadMainD    = 1'b0;
    loadMainSkid = 1'b0;
    loadSkid     = 1'b0;
    clearCtl     = 1'b0;
    if (flushE) begin
      stateNext = EMPTY;
      clearCtl  = 1'b1;
    end else begin
      case (state)
        EMPTY: if (accD) begin
          stateNext = BUSY;
          loadMainD = 1'b1;
        end
        BUSY: if (readyE) begin
          if (accD) begin
            loadMainD = 1'b1;
          end else begin
            stateNext = EMPTY;
            clearCtl  = 1'b1;
          end
        end else if (accD) begin
          stateNext = FULL;
          loadSkid  = 1'b1;
        end
        FULL: if (readyE) begin
          stateNext    = BUSY;
          loadMainSkid = 1'b1;
        end
        default: begin
          stateNext = EMPTY;
          clearCtl  = 1'b1;
        end
      endcase
    end
  end

  // Going empty zeroes only the control bits; the data fields keep their last value.
  always_comb begin
    mainD = {{CTL_W{1'b0}}, mainQ[PW-CTL_W-1:0]};
    if (loadMainD) begin
      mainD = dPayload;
    end else if (loadMainSkid) begin
      mainD = skidQ;
    end
  end

  assign mainEn = loadMainD | loadMainSkid | clearCtl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      readyQ <= 1'b1;
    end else begin
      state  <= stateNext;
      readyQ <= (stateNext != FULL);
    end
  end

  exreg_payload_reg #(.W(PW)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (mainEn),
    .d     (mainD),
    .q     (mainQ)
  );

  exreg_payload_reg #(.W(PW)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (loadSkid),
    .d     (dPayload),
    .q     (skidQ)
  );

  assign {RegWriteE, MemWriteE, MemReadE, aluFuncE, srcDataE1, srcDataE2, destAddE, pcE} = mainQ;

`ifdef EXREG_PERF_CNT_EN
  logic [CNTW-1:0] stallCnt, flushCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (validInt && !readyE && !(&stallCnt)) stallCnt <= stallCnt + CNTW'(1);
      if (flushE && (state != EMPTY) && !(&flushCnt)) flushCnt <= flushCnt + CNTW'(1);
    end
  end

  assign stallCntE = stallCnt;
  assign flushCntE = flushCnt;
`endif

endmodule
